// File: rtl/sync_filter.sv
// Multi-channel input conditioner: N-stage synchronizer, per-channel debounce filter,
// and registered rise/fall pulses, all advancing only on the clock enable.
module sync_filter #(
    parameter int unsigned     WIDTH      = 1,
    parameter int unsigned     STAGES     = 3,
    parameter int unsigned     FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] INIT      = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    // Index 0 is the newest sample, STAGES-1 the synchronized value.
    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]             out_q, out_d;
    logic [WIDTH-1:0]             rise_q, rise_d;
    logic [WIDTH-1:0]             fall_q, fall_d;
    logic [WIDTH-1:0]             synced;

    assign synced = sync_q[STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{INIT}};
            cnt_q  <= '0;
            out_q  <= INIT;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // A change is accepted only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        sync_d = sync_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        if (en) begin
            sync_d = {sync_q[STAGES-2:0], in};
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (synced[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    out_d[i] = synced[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            rise_d = out_d & ~out_q;
            fall_d = ~out_d & out_q;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter: sample-history model plus hand-computed checkpoints.
module tb_sync_filter;

    localparam int unsigned W   = 2;
    localparam int unsigned STG = 3;
    localparam int unsigned FL  = 4;

    logic         clk;
    logic         rst_n, rst1_n;
    logic         en;
    logic [W-1:0] in0, in1;
    logic [W-1:0] out0, rise0, fall0;
    logic [W-1:0] out1, rise1, fall1;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    sync_filter #(.WIDTH(W), .STAGES(STG), .FILTER_LEN(FL), .INIT(2'b00)) dut0 (
        .clk(clk), .reset_n(rst_n), .en(en), .in(in0),
        .out(out0), .rise(rise0), .fall(fall0)
    );

    sync_filter #(.WIDTH(W), .STAGES(STG), .FILTER_LEN(FL), .INIT(2'b01)) dut1 (
        .clk(clk), .reset_n(rst1_n), .en(en), .in(in1),
        .out(out1), .rise(rise1), .fall(fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: the filter sees the input as sampled STG enabled edges earlier; a change is
    // accepted when FL consecutive enabled samples disagree with the current output.
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_sync, m_out, m_rise, m_fall;
    int           m_run[W];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist = {};
            repeat (STG) m_hist.push_back(2'b00);
            m_out  = 2'b00;
            m_rise = 2'b00;
            m_fall = 2'b00;
            for (int c = 0; c < int'(W); c++) m_run[c] = 0;
        end else begin
            m_rise = 2'b00;
            m_fall = 2'b00;
            if (en && m_hist.size() == STG) begin
                m_sync = m_hist.pop_front();
                m_hist.push_back(in0);
                for (int c = 0; c < int'(W); c++) begin
                    if (m_sync[c] != m_out[c]) begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == int'(FL)) begin
                            m_out[c] = m_sync[c];
                            m_run[c] = 0;
                            if (m_sync[c]) m_rise[c] = 1'b1;
                            else           m_fall[c] = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            chk("model_out",  32'(out0),  32'(m_out));
            chk("model_rise", 32'(rise0), 32'(m_rise));
            chk("model_fall", 32'(fall0), 32'(m_fall));
        end
    end

    initial begin
        bit found;
        int n_en;

        rst_n  = 1'b0;
        rst1_n = 1'b0;
        en     = 1'b0;
        in0    = 2'b00;
        in1    = 2'b01;
        tick(2);
        chk("rst_out0",  32'(out0),  32'h0);
        chk("rst_rise0", 32'(rise0), 32'h0);
        chk("rst_fall0", 32'(fall0), 32'h0);
        chk("rst_out1",  32'(out1),  32'h1);

        rst_n  = 1'b1;
        rst1_n = 1'b1;
        en     = 1'b1;
        cmp_on = 1'b1;

        // Quiet input after reset: nothing moves.
        for (int k = 0; k < 20; k++) begin
            tick(1);
            chk("t1_out",  32'(out0),  32'h0);
            chk("t1_edge", 32'({rise0, fall0}), 32'h0);
        end

        // Single step on channel 0: accepted on the 7th edge after the change.
        in0 = 2'b01;
        tick(6);
        chk("t2_out_pre",   32'(out0),  32'h0);
        chk("t2_model_pre", 32'(m_out), 32'h0);
        tick(1);
        chk("t2_out",   32'(out0),  32'h1);
        chk("t2_rise",  32'(rise0), 32'h1);
        chk("t2_fall",  32'(fall0), 32'h0);
        chk("t2_model", 32'(m_out), 32'h1);
        tick(1);
        chk("t2_rise_end", 32'(rise0), 32'h0);
        chk("t2_out_hold", 32'(out0),  32'h1);

        // Three-cycle glitch on channel 1 is rejected.
        in0 = 2'b11;
        tick(3);
        in0 = 2'b01;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            chk("t3_out",  32'(out0), 32'h1);
            chk("t3_edge", 32'({rise0, fall0}), 32'h0);
        end

        // Decimated sampling: en high one cycle in four.
        in0 = 2'b00;
        tick(12);
        chk("t4_settle", 32'(out0), 32'h0);
        in0   = 2'b01;
        found = 1'b0;
        n_en  = 0;
        for (int k = 0; k < 100; k++) begin
            if (out0[0]) begin
                found = 1'b1;
                break;
            end
            en = (k % 4 == 0);
            if (en) n_en++;
            tick(1);
        end
        chk("t4_found",   32'(found), 32'h1);
        chk("t4_samples", 32'(n_en),  32'd7);
        chk("t4_rise",    32'(rise0), 32'h1);
        en = 1'b0;
        tick(1);
        chk("t4_rise_end", 32'(rise0), 32'h0);
        chk("t4_out_hold", 32'(out0),  32'h1);
        en = 1'b1;

        // Simultaneous changes on both channels pulse together.
        in0 = 2'b00;
        tick(12);
        chk("t5_settle", 32'(out0), 32'h0);
        in0 = 2'b11;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (out0 != 2'b00) break;
        end
        chk("t5_out_hi", 32'(out0),  32'h3);
        chk("t5_rise",   32'(rise0), 32'h3);
        chk("t5_fall0",  32'(fall0), 32'h0);
        in0 = 2'b00;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (out0 != 2'b11) break;
        end
        chk("t5_out_lo", 32'(out0),  32'h0);
        chk("t5_fall",   32'(fall0), 32'h3);
        chk("t5_rise0",  32'(rise0), 32'h0);

        // Reset mid-count on the INIT=01 instance.
        in1 = 2'b00;
        tick(5);
        chk("t6_pending", 32'(out1), 32'h1);
        #2 rst1_n = 1'b0;
        #1;
        chk("t6_rst_out",  32'(out1), 32'h1);
        chk("t6_rst_edge", 32'({rise1, fall1}), 32'h0);
        in1 = 2'b01;
        tick(1);
        rst1_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            chk("t6_out",  32'(out1), 32'h1);
            chk("t6_edge", 32'({rise1, fall1}), 32'h0);
        end
        in1 = 2'b00;
        tick(6);
        chk("t6_fresh_pre", 32'(out1), 32'h1);
        tick(1);
        chk("t6_fresh_out",  32'(out1),  32'h0);
        chk("t6_fresh_fall", 32'(fall1), 32'h1);

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
